// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with fixed-latency start/busy handshake
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_thi, r_tlo, r_hi, r_lo;
  logic        r_upd;
  logic        w_mul, w_div, w_commit;
  logic [31:0] w_b, w_sq, w_sr, w_thi, w_tlo;
  logic [63:0] w_ps, w_pu;
  assign w_mul = (MDOp == 4'd1) || (MDOp == 4'd2);
  assign w_div = (MDOp == 4'd3) || (MDOp == 4'd4);
  assign busy  = (r_state == RUN);
  assign start = (w_mul || w_div) && !req && !busy;
  assign w_commit = busy && (r_cnt == CW'(1));
  assign w_ps = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_pu = {32'b0, A} * {32'b0, B};
  // divisor forced non-zero so the quotient never goes X; a zero divisor skips the commit
  assign w_b  = (B == 32'd0) ? 32'd1 : B;
  assign w_sq = $signed(A) / $signed(w_b);
  assign w_sr = $signed(A) % $signed(w_b);
  assign w_thi = (MDOp == 4'd1) ? w_ps[63:32] : (MDOp == 4'd2) ? w_pu[63:32] :
                 (MDOp == 4'd3) ? w_sr : A % w_b;
  assign w_tlo = (MDOp == 4'd1) ? w_ps[31:0] : (MDOp == 4'd2) ? w_pu[31:0] :
                 (MDOp == 4'd3) ? w_sq : A / w_b;
  assign HI = r_hi;
  assign LO = r_lo;
  assign MDOut = (MDOp == 4'd7) ? r_hi : (MDOp == 4'd8) ? r_lo : 32'd0;
  always_comb begin
    w_state_nx = r_state;
    if (r_state == IDLE && start) w_state_nx = RUN;
    else if (w_commit) w_state_nx = IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_thi <= '0;
      r_tlo <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_upd <= 1'b0;
    end else begin
      if (start) begin
        r_cnt <= w_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        r_thi <= w_thi;
        r_tlo <= w_tlo;
        r_upd <= w_mul || (B != 32'd0);
      end else if (busy) r_cnt <= r_cnt - 1'b1;
      if (w_commit && r_upd) begin
        r_hi <= r_thi;
        r_lo <= r_tlo;
      end
      if (!req && !busy && MDOp == 4'd5) r_hi <= A;
      if (!req && !busy && MDOp == 4'd6) r_lo <= A;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset, req;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] HI, LO, MDOut;
  typedef struct packed {logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .MDOp(MDOp), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n, input bit intrude);
    int cnt;
    exp_t e;
    MDOp = op; A = a; B = b; req = 1'b0;
    #1 check({tag, " start"}, {31'b0, start}, 32'd1);
    sb.push_back('{hi: eh, lo: el});
    tick();
    MDOp = intrude ? 4'd6 : 4'd0;
    A = 32'h55;
    #1 check({tag, " start while busy"}, {31'b0, start}, 32'd0);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
      MDOp = 4'd0;
    end
    check({tag, " busy cycles"}, cnt, n);
    e = sb.pop_front();
    check({tag, " HI"}, HI, e.hi);
    check({tag, " LO"}, LO, e.lo);
  endtask
  initial begin
    reset = 1'b0; req = 1'b0; MDOp = 4'd0; A = '0; B = '0;
    repeat (3) tick();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset MDOut", MDOut, 32'd0);
    reset = 1'b1;
    tick();
    run_md("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b1);
    run_md("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
    run_md("div", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    run_md("div neg divisor", 4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 1'b0);
    run_md("divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0);
    MDOp = 4'd5; A = 32'h11;
    tick();
    check("mthi 0x11", HI, 32'h11);
    MDOp = 4'd6; A = 32'h22;
    tick();
    check("mtlo 0x22", LO, 32'h22);
    run_md("divu by zero", 4'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10, 1'b0);
    MDOp = 4'd5; A = 32'hABCD; req = 1'b1;
    tick();
    check("mthi req", HI, 32'h11);
    req = 1'b0;
    tick();
    check("mthi", HI, 32'hABCD);
    MDOp = 4'd7;
    #1 check("mfhi", MDOut, 32'hABCD);
    MDOp = 4'd8;
    #1 check("mflo", MDOut, 32'h22);
    MDOp = 4'd9;
    #1 check("MDOut other op", MDOut, 32'd0);
    MDOp = 4'd1; A = 32'd3; B = 32'd4; req = 1'b1;
    #1 check("mult req start", {31'b0, start}, 32'd0);
    tick();
    check("mult req busy", {31'b0, busy}, 32'd0);
    req = 1'b0; MDOp = 4'd3; A = 32'd100; B = 32'd7;
    tick();
    MDOp = 4'd0;
    repeat (3) tick();
    check("div running", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid-div reset busy", {31'b0, busy}, 32'd0);
    check("mid-div reset HI", HI, 32'd0);
    check("mid-div reset LO", LO, 32'd0);
    repeat (12) tick();
    check("no late commit HI", HI, 32'd0);
    check("no late commit LO", LO, 32'd0);
    check("no late busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run_md("post-reset mult", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0);
    check("scoreboard empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit of the P7 pipeline, in the EX stage beside the ALU. It executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo against private HI/LO registers. Multi-cycle operations run with a fixed latency. The block drives the `start`/`busy` pair that the hazard unit uses to stall md-class instructions in ID. Writes are suppressed when an exception/interrupt flush (`req`) is taken in the same cycle.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled only on rising clk
- req  in  1  exception/interrupt flush of the EX instruction this cycle
- MDOp  in  4  EX-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others = none
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- start  out  1  combinational; 1 when an operation is accepted this cycle
- busy  out  1  registered; 1 while a multi-cycle operation is in progress
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
- MDOut  out  32  HI when MDOp=7, LO when MDOp=8, else 0

## Operation
- State machine:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter `cnt` active.
- start = (MDOp∈{1..4}) & ~req & ~busy.
- IDLE → RUN on start:
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - Latch the result into temp registers tHI/tLO, computed from the A/B sampled that cycle.
- RUN:
  - cnt decrements each cycle.
  - When cnt==1: commit HI←tHI, LO←tLO, go to IDLE.
- Arithmetic, all 32-bit operands:
  - mult: signed 64-bit product; HI = [63:32], LO = [31:0].
  - multu: the same product, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: the unsigned equivalents.
- Divide by zero (B==0): full DIV_CYCLES busy period; HI/LO are left unchanged at commit.
- mthi/mtlo: HI←A or LO←A at the end of the cycle, when ~req & ~busy. Not multi-cycle; start stays 0.
- mfhi/mflo: read-only via MDOut; no state change.
- Ops arriving while busy=1 (hazard-protocol violation): ignored. This covers start, mthi and mtlo; the running operation is not disturbed.
- req does not abort an operation already in RUN. It only blocks acceptance of the current EX op.
- reset low: in the same edge busy←0, cnt←0, HI←0, LO←0, tHI/tLO←0, state←IDLE. This overrides any op in progress or presented.

## Timing
- Reset values: busy=0, HI=0, LO=0. MDOut=0 unless MDOp is 7 or 8. start follows its combinational equation.
- Operation accepted in cycle T (start=1 in T):
  - busy=1 in cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO show the new result from cycle T+N+1.
  - busy=0 in cycle T+N+1.
  - A new start is possible in T+N+1.
- Stall window: busy|start is high from cycle T through T+N. An mfhi sitting in ID during that window is held until HI is final.
- mthi/mtlo in cycle T: HI/LO are visible in T+1. MDOut reflects registered HI/LO, so there is no same-cycle bypass.
- Back-to-back: mthi in T followed by mfhi in T+1 returns the new value.

## Test plan
- mult, A=0xFFFFFFFD (-3), B=5, start in cycle 1:
  - busy=1 in cycles 2–6.
  - From cycle 7: HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy=0.
- multu, A=0xFFFFFFFF, B=2: after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div then divu:
  - div, A=0xFFFFFFF9 (-7), B=2: after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=7, B=0, with HI=0x11, LO=0x22 beforehand: busy for 10 cycles; HI/LO remain 0x11/0x22 afterwards.
- mthi, A=0xABCD with req=1: HI unchanged.
  - Repeat with req=0: HI=0xABCD next cycle.
  - Then MDOp=7: MDOut=0xABCD.
  - mult presented with req=1: start=0, busy stays 0.
- During mult busy (cycle 3), present mtlo with A=0x55: LO unaffected; final LO is the mult result.
- Reset and post-reset start:
  - Drive reset=0 in cycle 4 of a div: next cycle busy=0, HI=LO=0, and no later commit occurs.
  - A start in the first cycle after reset is accepted.
